result_readback: RTL and testbench



---
 rtl/cnn_io_pkg.sv | 16 +
 rtl/result_fifo.sv | 63 ++++++
 rtl/result_readback.sv | 169 ++++++++++++++++
 tb/tb_result_readback.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_io_pkg.sv
// Shared definitions for the CNN result readback path: controller states and
// the bit positions of the host-visible status word.
`timescale 1ns/1ps
package cnn_io_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } rb_state_e;

  // Status word layout returned on reads outside of STREAM.
  localparam int STATUS_DONE_BIT = 31;
  localparam int STATUS_ERR_BIT  = 30;

endpackage

// File: rtl/result_fifo.sv
// Result word FIFO: power-of-two depth, wrapping pointers, explicit occupancy
// counter so full and empty are unambiguous. Simultaneous push and pop both
// take effect, including on a full FIFO.
`timescale 1ns/1ps
module result_fifo #(
  parameter int DATA_WIDTH      = 32,
  parameter int FIFO_DEPTH      = 16,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty
);

  localparam int OCC_W = FIFO_DEPTH_LOG2 + 1;

  logic [DATA_WIDTH-1:0]      mem [FIFO_DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [OCC_W-1:0]           occupancy;
  logic                       do_push;
  logic                       do_pop;

  assign full     = (occupancy == OCC_W'(FIFO_DEPTH));
  assign empty    = (occupancy == '0);
  assign pop_data = mem[rd_ptr];

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  // Storage write.
  // NOTE: the storage array has no reset; occupancy alone defines which
  // entries are valid, so clearing the data would only cost flops and muxes.
  always_ff @(posedge wb_clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: rtl/result_readback.sv
// Wishbone slave that lets the host request N CNN result words and then read
// them back one per Wishbone read. Results are buffered in result_fifo; reads
// that find the FIFO empty are held in a wait state until a word arrives.
`timescale 1ns/1ps
module result_readback
  import cnn_io_pkg::*;
#(
  parameter int DATA_WIDTH            = 32,
  parameter int FIFO_DEPTH            = 16,
  parameter int FIFO_DEPTH_LOG2       = 4,
  parameter int MAX_RESULT_COUNT      = 512,
  parameter int MAX_RESULT_COUNT_LOG2 = 9
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [DATA_WIDTH-1:0] wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [DATA_WIDTH-1:0] wbs_dat_o,
  input  logic [DATA_WIDTH-1:0] result_data_i,
  input  logic                  result_valid_i,
  output logic                  result_ready_o,
  output logic                  readback_done,
  output logic                  count_error
);

  localparam int                CNT_W   = MAX_RESULT_COUNT_LOG2 + 1;
  localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_RESULT_COUNT);

  rb_state_e             state_q, state_d;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      pushed_q;
  logic [CNT_W-1:0]      read_q;

  logic                  req;
  logic [CNT_W-1:0]      wr_count;
  logic                  count_ok;
  logic                  last_pop;

  logic                  ack_d;
  logic [DATA_WIDTH-1:0] dat_d;
  logic                  load_count;
  logic                  err_set;
  logic                  err_clr;
  logic                  read_inc;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [DATA_WIDTH-1:0] idle_status;
  logic [DATA_WIDTH-1:0] done_status;

  // A request is only new while the previous ack is not being presented.
  assign req      = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign wr_count = wbs_dat_i[CNT_W-1:0];
  assign count_ok = (wr_count != '0) && (wr_count <= MAX_CNT);
  assign last_pop = ((read_q + CNT_W'(1)) == count_q);

  result_fifo #(
    .DATA_WIDTH      (DATA_WIDTH),
    .FIFO_DEPTH      (FIFO_DEPTH),
    .FIFO_DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .push      (fifo_push),
    .push_data (result_data_i),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // State register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state and bus transaction decode.
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    ack_d      = 1'b0;
    dat_d      = '0;
    fifo_pop   = 1'b0;
    load_count = 1'b0;
    err_set    = 1'b0;
    err_clr    = 1'b0;
    read_inc   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (req) begin
          ack_d = 1'b1;
          if (wbs_we_i) begin
            load_count = 1'b1;
            if (count_ok) begin
              state_d = STREAM;
              err_clr = 1'b1;
            end else begin
              state_d = IDLE;
              err_set = 1'b1;
            end
          end else begin
            dat_d = (state_q == DONE) ? done_status : idle_status;
          end
        end
      end
      STREAM: begin
        if (req) begin
          if (wbs_we_i) begin
            ack_d = 1'b1;
          end else if (!fifo_empty) begin
            // An empty FIFO leaves the request pending: no ack, no stale data.
            fifo_pop = 1'b1;
            ack_d    = 1'b1;
            dat_d    = fifo_head;
            read_inc = 1'b1;
            if (last_pop) state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs, CNN-side handshake and status words.
  always_comb begin
    idle_status                  = '0;
    idle_status[STATUS_ERR_BIT]  = count_error;
    done_status                  = '0;
    done_status[STATUS_DONE_BIT] = 1'b1;
    done_status[CNT_W-1:0]       = count_q;
    result_ready_o = (state_q == STREAM) & ~fifo_full & (pushed_q < count_q);
    readback_done  = (state_q == DONE);
    fifo_push      = result_valid_i & result_ready_o;
  end

  // Registered bus response, counters and error flag.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o   <= 1'b0;
      wbs_dat_o   <= '0;
      count_q     <= '0;
      pushed_q    <= '0;
      read_q      <= '0;
      count_error <= 1'b0;
    end else begin
      wbs_ack_o <= ack_d;
      wbs_dat_o <= dat_d;
      if (load_count) begin
        count_q  <= wr_count;
        pushed_q <= '0;
        read_q   <= '0;
      end else begin
        if (fifo_push) pushed_q <= pushed_q + 1'b1;
        if (read_inc)  read_q   <= read_q + 1'b1;
      end
      if (err_set)      count_error <= 1'b1;
      else if (err_clr) count_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_result_readback.sv
// Directed bench for result_readback: a table of host/CNN transactions with
// hand-computed expectations, plus hand-written multi-cycle sequences for
// backpressure, wait states, cancellation and mid-transfer reset.
`timescale 1ns/1ps
module tb_result_readback;

  typedef enum logic [1:0] {OP_WR, OP_RD, OP_PUSH} op_e;

  typedef struct {
    op_e         op;
    logic [31:0] din;
    logic [31:0] exp_dat;
    logic        exp_err;
    logic        exp_done;
  } vec_t;

  logic        wb_clk_i;
  logic        wb_rst_i;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [31:0] result_data_i;
  logic        result_valid_i;
  logic        result_ready_o;
  logic        readback_done;
  logic        count_error;

  int errors = 0;
  int checks = 0;

  result_readback dut (
    .wb_clk_i       (wb_clk_i),
    .wb_rst_i       (wb_rst_i),
    .wbs_cyc_i      (wbs_cyc_i),
    .wbs_stb_i      (wbs_stb_i),
    .wbs_we_i       (wbs_we_i),
    .wbs_dat_i      (wbs_dat_i),
    .wbs_ack_o      (wbs_ack_o),
    .wbs_dat_o      (wbs_dat_o),
    .result_data_i  (result_data_i),
    .result_valid_i (result_valid_i),
    .result_ready_o (result_ready_o),
    .readback_done  (readback_done),
    .count_error    (count_error)
  );

  initial begin
    wb_clk_i = 1'b0;
    forever #5 wb_clk_i = ~wb_clk_i;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance to one time unit after the next rising edge; all driving and
  // sampling happens at this point.
  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic do_reset();
    wb_rst_i = 1'b1;
    step();
    step();
    wb_rst_i = 1'b0;
  endtask

  // One Wishbone transfer; returns whether an ack arrived within max_wait cycles.
  task automatic wb_xfer(input logic we, input logic [31:0] din, input int max_wait,
                         output logic got_ack, output logic [31:0] dout);
    got_ack   = 1'b0;
    dout      = '0;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_dat_i = din;
    for (int c = 0; c < max_wait; c++) begin
      step();
      if (wbs_ack_o) begin
        got_ack = 1'b1;
        dout    = wbs_dat_o;
        break;
      end
    end
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    wbs_dat_i = '0;
  endtask

  // Offer one result word; returns whether it was accepted within max_wait cycles.
  task automatic cnn_push(input logic [31:0] word, input int max_wait, output logic ok);
    ok             = 1'b0;
    result_valid_i = 1'b1;
    result_data_i  = word;
    for (int c = 0; c < max_wait; c++) begin
      ok = result_ready_o;
      step();
      if (ok) break;
    end
    result_valid_i = 1'b0;
    result_data_i  = '0;
  endtask

  vec_t        vecs [22];
  logic        got;
  logic [31:0] rd;
  logic        ok;
  logic        was_ready;
  int          accepted;
  int          ready_cycles;
  int          no_ack;

  initial begin
    vecs[0]  = '{OP_WR,   32'd4,         32'h0,        1'b0, 1'b0};
    vecs[1]  = '{OP_PUSH, 32'hA0,        32'h0,        1'b0, 1'b0};
    vecs[2]  = '{OP_PUSH, 32'hA1,        32'h0,        1'b0, 1'b0};
    vecs[3]  = '{OP_PUSH, 32'hA2,        32'h0,        1'b0, 1'b0};
    vecs[4]  = '{OP_PUSH, 32'hA3,        32'h0,        1'b0, 1'b0};
    vecs[5]  = '{OP_RD,   32'h0,         32'hA0,       1'b0, 1'b0};
    vecs[6]  = '{OP_RD,   32'h0,         32'hA1,       1'b0, 1'b0};
    vecs[7]  = '{OP_RD,   32'h0,         32'hA2,       1'b0, 1'b0};
    vecs[8]  = '{OP_RD,   32'h0,         32'hA3,       1'b0, 1'b1};
    vecs[9]  = '{OP_RD,   32'h0,         32'h80000004, 1'b0, 1'b1};
    vecs[10] = '{OP_WR,   32'd0,         32'h0,        1'b1, 1'b0};
    vecs[11] = '{OP_WR,   32'd513,       32'h0,        1'b1, 1'b0};
    vecs[12] = '{OP_RD,   32'h0,         32'h40000000, 1'b1, 1'b0};
    vecs[13] = '{OP_WR,   32'd3,         32'h0,        1'b0, 1'b0};
    vecs[14] = '{OP_WR,   32'd7,         32'h0,        1'b0, 1'b0};
    vecs[15] = '{OP_PUSH, 32'h11,        32'h0,        1'b0, 1'b0};
    vecs[16] = '{OP_PUSH, 32'h22,        32'h0,        1'b0, 1'b0};
    vecs[17] = '{OP_RD,   32'h0,         32'h11,       1'b0, 1'b0};
    vecs[18] = '{OP_PUSH, 32'h33,        32'h0,        1'b0, 1'b0};
    vecs[19] = '{OP_RD,   32'h0,         32'h22,       1'b0, 1'b0};
    vecs[20] = '{OP_RD,   32'h0,         32'h33,       1'b0, 1'b1};
    vecs[21] = '{OP_RD,   32'h0,         32'h80000003, 1'b0, 1'b1};

    wb_rst_i       = 1'b1;
    wbs_cyc_i      = 1'b0;
    wbs_stb_i      = 1'b0;
    wbs_we_i       = 1'b0;
    wbs_dat_i      = '0;
    result_data_i  = '0;
    result_valid_i = 1'b0;

    // Reset state.
    step();
    check("reset ack",   32'(wbs_ack_o),      32'd0);
    check("reset dat",   wbs_dat_o,           32'd0);
    check("reset ready", 32'(result_ready_o), 32'd0);
    check("reset done",  32'(readback_done),  32'd0);
    check("reset err",   32'(count_error),    32'd0);
    do_reset();

    // Table: normal readback, bad counts, ignored STREAM write, interleaving.
    for (int i = 0; i < 22; i++) begin
      if (vecs[i].op == OP_PUSH) begin
        cnn_push(vecs[i].din, 20, ok);
        check($sformatf("vec%0d push accepted", i), 32'(ok), 32'd1);
      end else begin
        wb_xfer(vecs[i].op == OP_WR, vecs[i].din, 20, got, rd);
        check($sformatf("vec%0d ack", i),  32'(got),           32'd1);
        check($sformatf("vec%0d dat", i),  rd,                 vecs[i].exp_dat);
        check($sformatf("vec%0d err", i),  32'(count_error),   32'(vecs[i].exp_err));
        check($sformatf("vec%0d done", i), 32'(readback_done), 32'(vecs[i].exp_done));
      end
    end

    // Backpressure: 20 requested, continuous pushes, FIFO holds 16.
    do_reset();
    wb_xfer(1'b1, 32'd20, 20, got, rd);
    check("bp write ack", 32'(got), 32'd1);
    accepted       = 0;
    result_valid_i = 1'b1;
    result_data_i  = 32'h100;
    for (int c = 0; c < 25; c++) begin
      was_ready = result_ready_o;
      step();
      if (was_ready) begin
        accepted++;
        result_data_i = 32'h100 + 32'(accepted);
      end
    end
    check("bp accepted when full", 32'(accepted),       32'd16);
    check("bp ready when full",    32'(result_ready_o), 32'd0);
    // One read frees exactly one slot while the CNN keeps offering.
    got          = 1'b0;
    rd           = '0;
    ready_cycles = 0;
    wbs_cyc_i    = 1'b1;
    wbs_stb_i    = 1'b1;
    wbs_we_i     = 1'b0;
    for (int c = 0; c < 6; c++) begin
      was_ready = result_ready_o;
      step();
      if (was_ready) begin
        accepted++;
        ready_cycles++;
        result_data_i = 32'h100 + 32'(accepted);
      end
      if (wbs_ack_o && !got) begin
        got       = 1'b1;
        rd        = wbs_dat_o;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
      end
    end
    result_valid_i = 1'b0;
    check("bp read ack",         32'(got),          32'd1);
    check("bp read data",        rd,                32'h100);
    check("bp ready cycles",     32'(ready_cycles), 32'd1);
    check("bp accepted after",   32'(accepted),     32'd17);

    // Read waits on an empty FIFO, then completes once a word arrives.
    do_reset();
    wb_xfer(1'b1, 32'd2, 20, got, rd);
    check("wait write ack", 32'(got), 32'd1);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = 1'b0;
    no_ack    = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (!wbs_ack_o) no_ack++;
    end
    check("wait no ack while empty", 32'(no_ack), 32'd5);
    cnn_push(32'h55, 1, ok);
    check("wait push accepted", 32'(ok),        32'd1);
    check("wait ack at push",   32'(wbs_ack_o), 32'd0);
    step();
    check("wait ack after pop", 32'(wbs_ack_o), 32'd1);
    check("wait data",          wbs_dat_o,      32'h55);
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    // Cancelled wait: request dropped while empty, nothing consumed.
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    no_ack    = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (!wbs_ack_o) no_ack++;
    end
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    check("cancel no ack", 32'(no_ack), 32'd3);
    cnn_push(32'h66, 5, ok);
    step();
    check("cancel no late ack", 32'(wbs_ack_o), 32'd0);
    wb_xfer(1'b0, 32'h0, 20, got, rd);
    check("cancel read ack",  32'(got),           32'd1);
    check("cancel read data", rd,                 32'h66);
    check("cancel done",      32'(readback_done), 32'd1);

    // Reset in the middle of a read discards everything.
    do_reset();
    wb_xfer(1'b1, 32'd8, 20, got, rd);
    cnn_push(32'h1, 5, ok);
    cnn_push(32'h2, 5, ok);
    cnn_push(32'h3, 5, ok);
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = 1'b0;
    step();
    check("rst pre ack", 32'(wbs_ack_o), 32'd1);
    #1;
    wb_rst_i = 1'b1;
    #1;
    check("rst async ack",   32'(wbs_ack_o),      32'd0);
    check("rst async dat",   wbs_dat_o,           32'd0);
    check("rst async ready", 32'(result_ready_o), 32'd0);
    check("rst async done",  32'(readback_done),  32'd0);
    check("rst async err",   32'(count_error),    32'd0);
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    step();
    wb_rst_i = 1'b0;
    step();
    check("rst no ack after release", 32'(wbs_ack_o), 32'd0);
    wb_xfer(1'b0, 32'h0, 20, got, rd);
    check("rst status ack",  32'(got), 32'd1);
    check("rst status data", rd,       32'h0);
    // FIFO must be empty: a read in a fresh stream has to wait.
    wb_xfer(1'b1, 32'd1, 20, got, rd);
    wb_xfer(1'b0, 32'h0, 4, got, rd);
    check("rst fifo flushed", 32'(got), 32'd0);
    cnn_push(32'h77, 5, ok);
    wb_xfer(1'b0, 32'h0, 20, got, rd);
    check("rst fresh data", rd,                 32'h77);
    check("rst fresh done", 32'(readback_done), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
